// File: rtl/unpack_512_to_256.sv
// Width down-converter: splits each IN_W input word into two OUT_W beats, low half first.
// Supports half-word tails (low half only) and carries a last marker through to the beat stream.
module unpack_512_to_256 #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 256,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_half,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        LO,
        HI
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IN_W-1:0] data_buf;
    logic            half_flag;
    logic            last_flag;
    logic            load;
    logic            out_hs;

    // A new word may be loaded in the same cycle the final beat of the held word leaves,
    // which is what keeps a continuous stream bubble-free.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = data_buf[OUT_W-1:0];
        out_last   = last_flag && half_flag;

        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = LO;
                end
            end
            LO: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (half_flag) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = EMPTY;
                        end
                    end else begin
                        state_next = HI;
                    end
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_data  = data_buf[IN_W-1:OUT_W];
                out_last  = last_flag;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = LO;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Reset overrides every handshake in the cycle it is asserted.
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            load      = 1'b0;
        end
    end

    assign out_hs = out_valid && out_ready;

    // The upper half of a half-word is zeroed on capture so stale data can never leak out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            data_buf  <= '0;
            half_flag <= 1'b0;
            last_flag <= 1'b0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                data_buf  <= in_half ? {{(IN_W-OUT_W){1'b0}}, in_data[OUT_W-1:0]} : in_data;
                half_flag <= in_half;
                last_flag <= in_last;
                word_cnt  <= word_cnt + CNT_W'(1);
            end
            if (out_hs) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_unpack_512_to_256.sv
// Scoreboard bench for unpack_512_to_256: stimulus pushes expected beats, a monitor pops
// and compares on every output handshake. CNT_W=4 so counter wrap is reachable quickly.
module tb_unpack_512_to_256;

    localparam int IN_W  = 512;
    localparam int OUT_W = 256;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_half;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] beat_cnt;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    int    total_checks = 0;
    int    bad_checks   = 0;
    int    dead_seen    = 0;

    localparam logic [OUT_W-1:0] DEAD = {16{16'hDEAD}};

    always #5 clk = ~clk;

    unpack_512_to_256 #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_half  (in_half),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .word_cnt (word_cnt),
        .beat_cnt (beat_cnt)
    );

    function automatic logic [OUT_W-1:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual,
                               input logic [OUT_W-1:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL %s: actual=timeout required=event", name);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic applyStimulus(input logic [IN_W-1:0] d, input logic h, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_half  = h;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            failNow("accept_timeout");
        end else if (h) begin
            exp_q.push_back(beat_t'{data: d[OUT_W-1:0], last: l});
        end else begin
            exp_q.push_back(beat_t'{data: d[OUT_W-1:0], last: 1'b0});
            exp_q.push_back(beat_t'{data: d[IN_W-1:OUT_W], last: l});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        total_checks++;
        if (exp_q.size() != 0 || out_valid) begin
            bad_checks++;
            $display("[TB] FAIL drain: actual=%0d beats pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitOutValid(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) failNow(name);
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid) begin
            if (out_data == DEAD) dead_seen++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    total_checks++;
                    bad_checks++;
                    $display("[TB] FAIL unexpected_beat: actual=%h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_data", out_data, e.data);
                    checkOutput("beat_last", OUT_W'(out_last), OUT_W'(e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int valid_cycles;
        int ready_cycles;
        logic [7:0] b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_half   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", OUT_W'(in_ready), '0);
        checkOutput("rst_out_valid", OUT_W'(out_valid), '0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_last", OUT_W'(out_last), '0);
        checkOutput("rst_word_cnt", OUT_W'(word_cnt), '0);
        checkOutput("rst_beat_cnt", OUT_W'(beat_cnt), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
        @(posedge clk);
        #1;

        $display("[TB] single word");
        applyStimulus({fill(8'hBB), fill(8'hAA)}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("t1_word_cnt", OUT_W'(word_cnt), OUT_W'(1));
        checkOutput("t1_beat_cnt", OUT_W'(beat_cnt), OUT_W'(2));
        checkOutput("t1_in_ready", OUT_W'(in_ready), OUT_W'(1));

        $display("[TB] streaming");
        resetDut();
        valid_cycles = 0;
        ready_cycles = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    b = 8'(8'h10 + 2 * i);
                    applyStimulus({fill(b + 8'h01), fill(b)}, 1'b0, i == 3);
                end
            end
            begin
                waitOutValid("stream_start");
                for (int k = 0; k < 8; k++) begin
                    valid_cycles += int'(out_valid);
                    ready_cycles += int'(in_ready);
                    @(negedge clk);
                end
            end
        join
        waitDrain();
        checkOutput("t2_valid_cycles", OUT_W'(valid_cycles), OUT_W'(8));
        checkOutput("t2_hi_ready", OUT_W'(ready_cycles), OUT_W'(4));
        checkOutput("t2_word_cnt", OUT_W'(word_cnt), OUT_W'(4));
        checkOutput("t2_beat_cnt", OUT_W'(beat_cnt), OUT_W'(8));

        $display("[TB] half-word tail");
        resetDut();
        applyStimulus({fill(8'h22), fill(8'h21)}, 1'b0, 1'b0);
        applyStimulus({DEAD, fill(8'h31)}, 1'b1, 1'b1);
        waitDrain();
        checkOutput("t3_word_cnt", OUT_W'(word_cnt), OUT_W'(2));
        checkOutput("t3_beat_cnt", OUT_W'(beat_cnt), OUT_W'(3));
        checkOutput("t3_dead_seen", OUT_W'(dead_seen), '0);

        $display("[TB] backpressure");
        resetDut();
        out_ready = 1'b0;
        fork
            begin
                applyStimulus({fill(8'h42), fill(8'h41)}, 1'b0, 1'b0);
                applyStimulus({fill(8'h52), fill(8'h51)}, 1'b0, 1'b1);
            end
            begin
                waitOutValid("bp_start");
                for (int k = 0; k < 5; k++) begin
                    checkOutput("bp_lo_data", out_data, fill(8'h41));
                    checkOutput("bp_lo_last", OUT_W'(out_last), '0);
                    checkOutput("bp_lo_in_ready", OUT_W'(in_ready), '0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("bp_hi_data", out_data, fill(8'h42));
                    checkOutput("bp_hi_last", OUT_W'(out_last), '0);
                    checkOutput("bp_hi_in_ready", OUT_W'(in_ready), '0);
                end
                checkOutput("bp_word_cnt", OUT_W'(word_cnt), OUT_W'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("t4_word_cnt", OUT_W'(word_cnt), OUT_W'(2));
        checkOutput("t4_beat_cnt", OUT_W'(beat_cnt), OUT_W'(4));

        $display("[TB] reset mid-word");
        resetDut();
        out_ready = 1'b0;
        applyStimulus({fill(8'h62), fill(8'h61)}, 1'b0, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("mid_rst_out_valid", OUT_W'(out_valid), '0);
        checkOutput("mid_rst_in_ready", OUT_W'(in_ready), '0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_out_valid", OUT_W'(out_valid), '0);
        checkOutput("t5_word_cnt", OUT_W'(word_cnt), '0);
        checkOutput("t5_beat_cnt", OUT_W'(beat_cnt), '0);
        checkOutput("t5_in_ready", OUT_W'(in_ready), OUT_W'(1));
        @(posedge clk);
        #1;
        applyStimulus({fill(8'h72), fill(8'h71)}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("t5_word_cnt_after", OUT_W'(word_cnt), OUT_W'(1));
        checkOutput("t5_beat_cnt_after", OUT_W'(beat_cnt), OUT_W'(2));

        $display("[TB] counter wrap");
        resetDut();
        for (int i = 0; i < 9; i++) begin
            b = 8'(8'h80 + 2 * i);
            applyStimulus({fill(b + 8'h01), fill(b)}, 1'b0, i == 8);
        end
        waitDrain();
        checkOutput("t6_word_cnt", OUT_W'(word_cnt), OUT_W'(9));
        checkOutput("t6_beat_cnt", OUT_W'(beat_cnt), OUT_W'(2));

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
